// File: rtl/demux1x4_if.sv
// Handshake bundle for the registered 1:4 demultiplexer: one producer side, four consumer channels.
// Optional stat_cnt bus exists only when DEMUX_STATS_EN is defined.
interface demux1x4_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              i_ready;
  logic              s1;
  logic              s0;
  logic [DATA_W-1:0] o0;
  logic [DATA_W-1:0] o1;
  logic [DATA_W-1:0] o2;
  logic [DATA_W-1:0] o3;
  logic [3:0]        o_valid;
  logic [3:0]        o_ready;
`ifdef DEMUX_STATS_EN
  logic [4*CNT_W-1:0] stat_cnt;
`endif

  modport slave (
    input  i_data, i_valid, s1, s0, o_ready,
`ifdef DEMUX_STATS_EN
    output stat_cnt,
`endif
    output i_ready, o0, o1, o2, o3, o_valid
  );

  modport master (
    output i_data, i_valid, s1, s0, o_ready,
`ifdef DEMUX_STATS_EN
    input  stat_cnt,
`endif
    input  i_ready, o0, o1, o2, o3, o_valid
  );
endinterface

// File: rtl/demux1x4_reg.sv
// Registered 1:4 demultiplexer: each output channel is a one-entry EMPTY/FULL holding register.
// Define DEMUX_STATS_EN to add per-channel wrapping delivery counters on stat_cnt.
module demux1x4_reg #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input logic       clk,
  input logic       rst,
  demux1x4_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  logic [1:0]        sel;
  logic [3:0]        load;
  logic [3:0]        drain;
  logic [3:0]        vld_p1;
  state_t            state_p1 [4];
  logic [DATA_W-1:0] data_p1  [4];

  assign sel = {bus.s1, bus.s0};

  // Only the addressed channel can stall the producer.
  assign bus.i_ready = ~rst & (~vld_p1[sel] | bus.o_ready[sel]);

  always_comb begin
    vld_p1 = '0;
    load   = '0;
    drain  = '0;
    for (int n = 0; n < 4; n++) begin
      vld_p1[n] = (state_p1[n] == FULL);
      load[n]   = bus.i_valid & bus.i_ready & (sel == 2'(n));
      drain[n]  = vld_p1[n] & bus.o_ready[n];
    end
  end

  // ---- stage p1: channel holding registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) begin
        state_p1[n] <= EMPTY;
        data_p1[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (load[n])
          data_p1[n] <= bus.i_data;
        case (state_p1[n])
          EMPTY:   if (load[n]) state_p1[n] <= FULL;
          FULL:    if (drain[n] && !load[n]) state_p1[n] <= EMPTY;
          default: state_p1[n] <= EMPTY;
        endcase
      end
    end
  end

  assign bus.o0      = data_p1[0];
  assign bus.o1      = data_p1[1];
  assign bus.o2      = data_p1[2];
  assign bus.o3      = data_p1[3];
  assign bus.o_valid = vld_p1;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_p1 [4];

  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

  // ---- stage p1: delivery counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) cnt_p1[n] <= '0;
    end else begin
      for (int n = 0; n < 4; n++)
        if (drain[n]) cnt_p1[n] <= wrap_inc(cnt_p1[n]);
    end
  end

  always_comb begin
    bus.stat_cnt = '0;
    for (int n = 0; n < 4; n++) bus.stat_cnt[n*CNT_W +: CNT_W] = cnt_p1[n];
  end
`endif

endmodule

// File: tb/tb_demux1x4_reg.sv
// Directed bench for demux1x4_reg: reset, routing, stall, independence, reset mid-op, optional stats.
module tb_demux1x4_reg;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  demux1x4_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  demux1x4_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s);
    bus.i_valid = v;
    bus.i_data  = d;
    {bus.s1, bus.s0} = s;
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    bus.o_ready = 4'b0000;
    drive(1'b1, 8'hFF, 2'b00);

    // reset held two cycles with i_valid high
    step(); step();
    check_val("rst_o_valid", {28'd0, bus.o_valid}, 32'h0);
    check_val("rst_o0", {24'd0, bus.o0}, 32'h0);
    check_val("rst_o1", {24'd0, bus.o1}, 32'h0);
    check_val("rst_o2", {24'd0, bus.o2}, 32'h0);
    check_val("rst_o3", {24'd0, bus.o3}, 32'h0);
    check_val("rst_i_ready", {31'd0, bus.i_ready}, 32'h0);
`ifdef DEMUX_STATS_EN
    check_val("rst_stat", bus.stat_cnt, 32'h0);
`endif

    // o_ready on empty channels is ignored
    rst = 1'b0;
    bus.o_ready = 4'b1111;
    drive(1'b0, 8'h00, 2'b00);
    step();
    check_val("idle_o_valid", {28'd0, bus.o_valid}, 32'h0);

    // routing, back-to-back, all consumers ready
    drive(1'b1, 8'hA1, 2'b00);
    check_val("rt_rdy0", {31'd0, bus.i_ready}, 32'h1);
    step();
    check_val("rt_o0", {24'd0, bus.o0}, 32'hA1);
    check_val("rt_v0", {28'd0, bus.o_valid}, 32'h1);
    drive(1'b1, 8'hB2, 2'b01);
    check_val("rt_rdy1", {31'd0, bus.i_ready}, 32'h1);
    step();
    check_val("rt_o1", {24'd0, bus.o1}, 32'hB2);
    check_val("rt_v1", {28'd0, bus.o_valid}, 32'h2);
    drive(1'b1, 8'hC3, 2'b10);
    check_val("rt_rdy2", {31'd0, bus.i_ready}, 32'h1);
    step();
    check_val("rt_o2", {24'd0, bus.o2}, 32'hC3);
    check_val("rt_v2", {28'd0, bus.o_valid}, 32'h4);
    drive(1'b1, 8'hD4, 2'b11);
    check_val("rt_rdy3", {31'd0, bus.i_ready}, 32'h1);
    step();
    check_val("rt_o3", {24'd0, bus.o3}, 32'hD4);
    check_val("rt_v3", {28'd0, bus.o_valid}, 32'h8);
    drive(1'b0, 8'h00, 2'b00);
    step();
    check_val("rt_drained", {28'd0, bus.o_valid}, 32'h0);
    check_val("rt_o0_kept", {24'd0, bus.o0}, 32'hA1);

    // stall on channel 2
    bus.o_ready = 4'b1011;
    drive(1'b1, 8'h5A, 2'b10);
    check_val("st_rdy_a", {31'd0, bus.i_ready}, 32'h1);
    step();
    check_val("st_o2_a", {24'd0, bus.o2}, 32'h5A);
    check_val("st_v_a", {28'd0, bus.o_valid}, 32'h4);
    drive(1'b1, 8'h6B, 2'b10);
    check_val("st_rdy_blk", {31'd0, bus.i_ready}, 32'h0);
    step();
    check_val("st_o2_held", {24'd0, bus.o2}, 32'h5A);
    check_val("st_rdy_blk2", {31'd0, bus.i_ready}, 32'h0);
    bus.o_ready = 4'b1111;
    #1;
    check_val("st_rdy_rel", {31'd0, bus.i_ready}, 32'h1);
    step();
    check_val("st_o2_b", {24'd0, bus.o2}, 32'h6B);
    check_val("st_v_b", {28'd0, bus.o_valid}, 32'h4);
    drive(1'b0, 8'h00, 2'b00);
    step();
    check_val("st_empty", {28'd0, bus.o_valid}, 32'h0);

    // independence: ch1 full and stalled, ch0 still accepts
    bus.o_ready = 4'b0000;
    drive(1'b1, 8'h99, 2'b01);
    step();
    check_val("in_o1", {24'd0, bus.o1}, 32'h99);
    drive(1'b1, 8'h77, 2'b00);
    check_val("in_rdy0", {31'd0, bus.i_ready}, 32'h1);
    step();
    check_val("in_o0", {24'd0, bus.o0}, 32'h77);
    check_val("in_o1_kept", {24'd0, bus.o1}, 32'h99);
    check_val("in_v", {28'd0, bus.o_valid}, 32'h3);
    drive(1'b1, 8'h55, 2'b01);
    check_val("in_rdy1_blk", {31'd0, bus.i_ready}, 32'h0);

    // fill ch3, then reset mid-operation
    drive(1'b1, 8'hD8, 2'b11);
    check_val("mr_rdy3", {31'd0, bus.i_ready}, 32'h1);
    step();
    check_val("mr_v_full", {28'd0, bus.o_valid}, 32'hB);
    check_val("mr_o3", {24'd0, bus.o3}, 32'hD8);
    bus.o_ready = 4'b1111;
    rst = 1'b1;
    drive(1'b1, 8'h12, 2'b00);
    check_val("mr_rdy_rst", {31'd0, bus.i_ready}, 32'h0);
    step();
    check_val("mr_v", {28'd0, bus.o_valid}, 32'h0);
    check_val("mr_o0", {24'd0, bus.o0}, 32'h0);
    check_val("mr_o3z", {24'd0, bus.o3}, 32'h0);
`ifdef DEMUX_STATS_EN
    check_val("mr_stat", bus.stat_cnt, 32'h0);
`endif
    rst = 1'b0;
    drive(1'b0, 8'h00, 2'b00);
    step();

`ifdef DEMUX_STATS_EN
    // 257 words through ch3 at full rate; counter wraps to 1
    bus.o_ready = 4'b1000;
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 8'(i + 1), 2'b11);
      step();
    end
    drive(1'b0, 8'h00, 2'b00);
    step();
    check_val("ss_ch3", {24'd0, bus.stat_cnt[31:24]}, 32'h01);
    check_val("ss_low", {8'd0, bus.stat_cnt[23:0]}, 32'h0);
    check_val("ss_v", {28'd0, bus.o_valid}, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("ss_rst", bus.stat_cnt, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
